// File: rtl/dark_count_roi_if.sv
// Video stream, ROI/threshold configuration and per-frame result bundle for dark_count_roi.
// Optional oRoiSum member exists only when DARK_COUNT_SUM_EN is defined.
interface dark_count_roi_if #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned COORD_W = 16,
    parameter int unsigned CNT_W   = 20
);
    logic                iFVAL;
    logic                iDVAL;
    logic [DATA_W-1:0]   iDATA;
    logic [DATA_W-1:0]   iTHRESH;
    logic [COORD_W-1:0]  iXSTART;
    logic [COORD_W-1:0]  iXEND;
    logic [COORD_W-1:0]  iYSTART;
    logic [COORD_W-1:0]  iYEND;
    logic                oDVAL;
    logic [CNT_W-1:0]    oDarkCounter;
    logic [CNT_W-1:0]    oFrameCount;
    logic                oFrameDone;
    logic                oFrameErr;
    logic                oSat;
`ifdef DARK_COUNT_SUM_EN
    logic [CNT_W+DATA_W-1:0] oRoiSum;
`endif

    modport master (
        output iFVAL, iDVAL, iDATA, iTHRESH, iXSTART, iXEND, iYSTART, iYEND,
        input  oDVAL, oDarkCounter, oFrameCount, oFrameDone, oFrameErr, oSat
`ifdef DARK_COUNT_SUM_EN
        , input oRoiSum
`endif
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA, iTHRESH, iXSTART, iXEND, iYSTART, iYEND,
        output oDVAL, oDarkCounter, oFrameCount, oFrameDone, oFrameErr, oSat
`ifdef DARK_COUNT_SUM_EN
        , output oRoiSum
`endif
    );
endinterface

// File: rtl/dark_count_roi.sv
// Per-frame count of pixels <= threshold inside a programmable ROI of a raster stream.
// Define DARK_COUNT_SUM_EN to add the saturating ROI pixel sum (oRoiSum).
module dark_count_roi #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned COORD_W  = 16,
    parameter int unsigned CNT_W    = 20
) (
    input  logic             iCLK,
    input  logic             iRST,
    dark_count_roi_if.slave  bus
);
    localparam int unsigned X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned SUM_W = CNT_W + DATA_W;
    localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_pix;
    logic               w_early;
    logic               w_done;
    logic               w_in_roi;
    logic               w_dark;

    logic               r_fval_d;
    logic               r_dval_d;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [DATA_W-1:0]  r_thresh;
    logic [COORD_W-1:0] r_xs;
    logic [COORD_W-1:0] r_xe;
    logic [COORD_W-1:0] r_ys;
    logic [COORD_W-1:0] r_ye;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               r_sat;

    // State register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pix       = 1'b0;
        w_early     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iFVAL && !r_fval_d) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                w_pix = bus.iDVAL;
                // The final pixel wins over a simultaneous falling iFVAL
                if (bus.iDVAL && (r_x == X_LAST) && (r_y == Y_LAST)) begin
                    w_state_nxt = S_DONE;
                end else if (!bus.iFVAL) begin
                    w_early     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_in_roi = (COORD_W'(r_x) >= r_xs) && (COORD_W'(r_x) < r_xe) &&
                      (COORD_W'(r_y) >= r_ys) && (COORD_W'(r_y) < r_ye);
    assign w_dark   = w_pix && w_in_roi && (bus.iDATA <= r_thresh);

    // Raster position, shadow config, counters and frame results
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_fval_d     <= 1'b0;
            r_dval_d     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_thresh     <= '0;
            r_xs         <= '0;
            r_xe         <= '0;
            r_ys         <= '0;
            r_ye         <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_fval_d     <= bus.iFVAL;
            r_dval_d     <= bus.iDVAL;
            r_frame_done <= w_done;
            if (w_start) begin
                r_x      <= '0;
                r_y      <= '0;
                r_cnt    <= '0;
                r_sat    <= 1'b0;
                r_err    <= 1'b0;
                r_thresh <= bus.iTHRESH;
                r_xs     <= bus.iXSTART;
                r_xe     <= bus.iXEND;
                r_ys     <= bus.iYSTART;
                r_ye     <= bus.iYEND;
            end
            if (w_pix) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            if (w_dark) begin
                if (r_cnt == CNT_MAX) r_sat <= 1'b1;
                else                  r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_early) r_err <= 1'b1;
            if (w_done) begin
                r_frame_cnt <= r_cnt;
                r_frame_err <= r_err;
            end
        end
    end

`ifdef DARK_COUNT_SUM_EN
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] r_roi_sum;
    logic [SUM_W:0]   w_sum_add;

    assign w_sum_add = {1'b0, r_sum} + (SUM_W+1)'(bus.iDATA);

    // Saturating sum of every ROI pixel, snapshotted at frame end
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_sum     <= '0;
            r_roi_sum <= '0;
        end else begin
            if (w_start)
                r_sum <= '0;
            else if (w_pix && w_in_roi)
                r_sum <= w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];
            if (w_done) r_roi_sum <= r_sum;
        end
    end

    assign bus.oRoiSum = r_roi_sum;
`endif

    assign bus.oDVAL        = r_dval_d;
    assign bus.oDarkCounter = r_cnt;
    assign bus.oFrameCount  = r_frame_cnt;
    assign bus.oFrameDone   = r_frame_done;
    assign bus.oFrameErr    = r_frame_err;
    assign bus.oSat         = r_sat;

endmodule

// File: tb/tb_dark_count_roi.sv
// Directed bench for dark_count_roi on a reduced 20x16 raster; DUT a (CNT_W=10) holds the full
// count, DUT b (CNT_W=8) shares the stimulus and exercises saturation. Covers DARK_COUNT_SUM_EN.
`timescale 1ns/1ps
module tb_dark_count_roi;
    localparam int unsigned DATA_W  = 10;
    localparam int unsigned H       = 20;
    localparam int unsigned V       = 16;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned CNT_A   = 10;
    localparam int unsigned CNT_B   = 8;
    localparam int          MAX_A   = (1 << CNT_A) - 1;
    localparam int          MAX_B   = (1 << CNT_B) - 1;

    typedef struct {
        int     cnt_a;
        int     cnt_b;
        bit     err;
        bit     sat_a;
        bit     sat_b;
        int     lat;
        longint sum;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dark_count_roi_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .CNT_W(CNT_A)) bus_a ();
    dark_count_roi_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .CNT_W(CNT_B)) bus_b ();

    assign bus_b.iFVAL   = bus_a.iFVAL;
    assign bus_b.iDVAL   = bus_a.iDVAL;
    assign bus_b.iDATA   = bus_a.iDATA;
    assign bus_b.iTHRESH = bus_a.iTHRESH;
    assign bus_b.iXSTART = bus_a.iXSTART;
    assign bus_b.iXEND   = bus_a.iXEND;
    assign bus_b.iYSTART = bus_a.iYSTART;
    assign bus_b.iYEND   = bus_a.iYEND;

    dark_count_roi #(.DATA_W(DATA_W), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(COORD_W), .CNT_W(CNT_A))
        u_dut_a (.iCLK(clk), .iRST(rst_n), .bus(bus_a));
    dark_count_roi #(.DATA_W(DATA_W), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(COORD_W), .CNT_W(CNT_B))
        u_dut_b (.iCLK(clk), .iRST(rst_n), .bus(bus_b));

    int     checks   = 0;
    int     failures = 0;
    exp_t   exp_q[$];
    int     m_raw    = 0;
    longint m_sum    = 0;
    bit     prev_dv  = 1'b0;
    logic   s_done;
    logic [63:0] s_fa, s_fb, s_err, s_sat_a, s_sat_b, s_sum;

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_cfg(input int thr, input int xs, input int xe, input int ys, input int ye);
        bus_a.iTHRESH = DATA_W'(thr);
        bus_a.iXSTART = COORD_W'(xs);
        bus_a.iXEND   = COORD_W'(xe);
        bus_a.iYSTART = COORD_W'(ys);
        bus_a.iYEND   = COORD_W'(ye);
    endtask

    // One clock: drive, check running outputs mid-cycle, snapshot frame results, advance
    task automatic cyc(input bit dv, input bit fv, input logic [DATA_W-1:0] d);
        bus_a.iDVAL = dv;
        bus_a.iFVAL = fv;
        bus_a.iDATA = d;
        @(negedge clk);
        chk("dark_cnt_a", 64'(bus_a.oDarkCounter), 64'(cap(m_raw, MAX_A)));
        chk("dark_cnt_b", 64'(bus_b.oDarkCounter), 64'(cap(m_raw, MAX_B)));
        chk("odval", 64'(bus_a.oDVAL), 64'(prev_dv));
        s_done  = bus_a.oFrameDone;
        s_fa    = 64'(bus_a.oFrameCount);
        s_fb    = 64'(bus_b.oFrameCount);
        s_err   = 64'(bus_a.oFrameErr);
        s_sat_a = 64'(bus_a.oSat);
        s_sat_b = 64'(bus_b.oSat);
`ifdef DARK_COUNT_SUM_EN
        s_sum   = 64'(bus_a.oRoiSum);
`else
        s_sum   = 64'd0;
`endif
        prev_dv = dv;
        @(posedge clk);
        #1;
    endtask

    // Drive one frame and push its expected result; abort_at>=0 resets mid-frame instead
    task automatic frame(input int npix, input int mode, input int val, input bit fall_last,
                         input int chg_at, input int abort_at);
        int   thr, xs, xe, ys, ye, x, y, nd;
        logic [DATA_W-1:0] d;
        exp_t e;
        thr = int'(bus_a.iTHRESH);
        xs = int'(bus_a.iXSTART); xe = int'(bus_a.iXEND);
        ys = int'(bus_a.iYSTART); ye = int'(bus_a.iYEND);
        cyc(1'b0, 1'b1, '0);
        m_raw = 0;
        m_sum = 0;
        chk("sat_clear_a", 64'(bus_a.oSat), 64'd0);
        chk("sat_clear_b", 64'(bus_b.oSat), 64'd0);
        for (int i = 0; i < npix; i++) begin
            if (i % 7 == 3) cyc(1'b0, 1'b1, '0);
            if (i == chg_at) bus_a.iXSTART = COORD_W'(15);
            if (i == abort_at) begin
                rst_n = 1'b0;
                bus_a.iDVAL = 1'b0;
                bus_a.iFVAL = 1'b0;
                @(negedge clk);
                chk("rst_dark_a", 64'(bus_a.oDarkCounter), 64'd0);
                chk("rst_frame_a", 64'(bus_a.oFrameCount), 64'd0);
                chk("rst_done_a", 64'(bus_a.oFrameDone), 64'd0);
                chk("rst_err_a", 64'(bus_a.oFrameErr), 64'd0);
                chk("rst_sat_b", 64'(bus_b.oSat), 64'd0);
                chk("rst_frame_b", 64'(bus_b.oFrameCount), 64'd0);
                @(posedge clk);
                #1;
                rst_n   = 1'b1;
                m_raw   = 0;
                prev_dv = 1'b0;
                nd = 0;
                for (int k = 0; k < 8; k++) begin
                    cyc(1'b0, 1'b0, '0);
                    if (s_done === 1'b1) nd++;
                end
                chk("no_done_after_rst", 64'(nd), 64'd0);
                return;
            end
            x = i % H;
            y = i / H;
            d = (mode == 1) ? DATA_W'(x) : DATA_W'(val);
            cyc(1'b1, !((i == npix - 1) && fall_last), d);
            if (x >= xs && x < xe && y >= ys && y < ye) begin
                m_sum += longint'(d);
                if (int'(d) <= thr) m_raw++;
            end
        end
        e.cnt_a = cap(m_raw, MAX_A);
        e.cnt_b = cap(m_raw, MAX_B);
        e.err   = (npix != H * V);
        e.sat_a = (m_raw > MAX_A);
        e.sat_b = (m_raw > MAX_B);
        e.lat   = ((npix == H * V) || fall_last) ? 2 : 3;
        e.sum   = m_sum;
        exp_q.push_back(e);
    endtask

    // Bounded wait for the done pulse, then pop and compare against the scoreboard
    task automatic wait_done(input bit tail);
        exp_t e;
        int   first_k, nd;
        logic [63:0] fa, fb, er, sa, sb, sm;
        first_k = 0;
        nd = 0;
        fa = '0; fb = '0; er = '0; sa = '0; sb = '0; sm = '0;
        for (int k = 1; k <= 7; k++) begin
            cyc(tail && (k <= 3), tail && (k <= 3), '0);
            if (s_done === 1'b1) begin
                nd++;
                if (first_k == 0) begin
                    first_k = k;
                    fa = s_fa; fb = s_fb; er = s_err; sa = s_sat_a; sb = s_sat_b; sm = s_sum;
                end
            end
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("done_latency", 64'(first_k), 64'(e.lat));
        chk("done_pulses", 64'(nd), 64'd1);
        chk("frame_cnt_a", fa, 64'(e.cnt_a));
        chk("frame_cnt_b", fb, 64'(e.cnt_b));
        chk("frame_err", er, 64'(e.err));
        chk("sat_a", sa, 64'(e.sat_a));
        chk("sat_b", sb, 64'(e.sat_b));
`ifdef DARK_COUNT_SUM_EN
        chk("roi_sum", sm, 64'(e.sum));
`endif
    endtask

    initial begin
        bus_a.iFVAL = 1'b0;
        bus_a.iDVAL = 1'b0;
        bus_a.iDATA = '0;
        set_cfg(0, 0, H, 0, V);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dark", 64'(bus_a.oDarkCounter), 64'd0);
        chk("reset_frame", 64'(bus_a.oFrameCount), 64'd0);
        chk("reset_done", 64'(bus_a.oFrameDone), 64'd0);
        chk("reset_err", 64'(bus_a.oFrameErr), 64'd0);
        chk("reset_sat", 64'(bus_a.oSat), 64'd0);
        chk("reset_dval", 64'(bus_a.oDVAL), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);

        // Full all-dark frame with trailing pixels that must be dropped; DUT b saturates
        set_cfg(0, 0, H, 0, V);
        frame(H * V, 0, 0, 1'b0, -1, -1);
        wait_done(1'b1);

        // Small ROI, pixel value equal to then above the threshold
        set_cfg(5, 5, 10, 3, 5);
        frame(H * V, 0, 5, 1'b0, -1, -1);
        wait_done(1'b0);
        set_cfg(4, 5, 10, 3, 5);
        frame(H * V, 0, 5, 1'b0, -1, -1);
        wait_done(1'b0);

        // Early falling iFVAL
        set_cfg(0, 0, H, 0, V);
        frame(100, 0, 0, 1'b0, -1, -1);
        wait_done(1'b0);

        // Column-valued pixels, iFVAL falls together with the final pixel
        set_cfg(9, 0, H, 0, V);
        frame(H * V, 1, 0, 1'b1, -1, -1);
        wait_done(1'b0);

        // Mid-frame XSTART change only applies from the next frame
        set_cfg(0, 0, H, 0, V);
        frame(H * V, 0, 0, 1'b0, 50, -1);
        wait_done(1'b0);
        frame(H * V, 0, 0, 1'b0, -1, -1);
        wait_done(1'b0);
        set_cfg(0, 8, 8, 0, V);
        frame(H * V, 0, 0, 1'b0, -1, -1);
        wait_done(1'b0);

        // Empty ROI in Y, then bounds beyond the raster
        set_cfg(1023, 0, H, 9, 3);
        frame(H * V, 0, 7, 1'b0, -1, -1);
        wait_done(1'b0);
        set_cfg(0, 10, 100, 8, 100);
        frame(H * V, 0, 0, 1'b0, -1, -1);
        wait_done(1'b0);

        // Reset mid-frame, then a clean full frame
        set_cfg(0, 0, H, 0, V);
        frame(H * V, 0, 0, 1'b0, -1, 30);
        frame(H * V, 0, 0, 1'b0, -1, -1);
        wait_done(1'b0);

        // Four ROI pixels valued 1..4
        set_cfg(1023, 1, 5, 0, 1);
        frame(H * V, 1, 0, 1'b0, -1, -1);
        wait_done(1'b0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
